// File: rtl/rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter
//
// Sole owner of the multiplexed address/data bus to the RTC chip. Two
// requesters share it: the periodic read scanner and the user write /
// configuration path. Each grant runs one complete bus transaction:
//   ADDR_SETUP -> ADDR_STROBE -> ADDR_HOLD ->
//   DATA_SETUP -> DATA_STROBE -> DATA_HOLD -> RECOVER -> IDLE
// Every phase state lasts PHASE_CYC clocks and RECOVER lasts RECOV_CYC clocks.
// A transaction therefore spans 6*PHASE_CYC + RECOV_CYC clocks, counted from
// the grant cycle through the last RECOVER cycle.
//
// Parameters:
//   PHASE_CYC  clocks per bus phase (1..255)
//   RECOV_CYC  clocks of chip-select high between transactions (1..255)
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   rd_req/rd_addr     read request (level) and register address
//   rd_grant           one-cycle pulse: read accepted
//   rd_data/rd_valid   read result and its one-cycle update pulse
//   wr_req/wr_addr/wr_data  write request (level), address and data
//   wr_grant           one-cycle pulse: write accepted
//   wr_done            one-cycle pulse: write strobe completed
//   busy               high in every state except IDLE
//   cs_n, ad_n, wr_n, rd_n  bus control strobes (ad_n: 0 = address phase)
//   ad_out/ad_oe       bus drive value and its tristate enable
//   ad_in              bus sampled value
//
// Configuration macro:
//   RTC_ARB_WR_PRIORITY_EN  defined   -> writes always win arbitration
//                           undefined -> round-robin between read and write
//
// Every output comes straight from a flop. The bus levels are decoded from
// the next state and registered, so they line up with the state register.
// ---------------------------------------------------------------------------
module rtc_bus_arbiter #(
  parameter int unsigned PHASE_CYC = 8,
  parameter int unsigned RECOV_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_grant,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_grant,
  output logic       wr_done,
  output logic       busy,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD,
    RECOVER
  } state_t;

  // The down-counter is loaded with length-1 on entry to a state and runs to zero.
  localparam logic [7:0] PHASE_LOAD = 8'(PHASE_CYC - 1);
  localparam logic [7:0] RECOV_LOAD = 8'(RECOV_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] data_q, data_nxt;
  logic       is_wr, is_wr_nxt;
  logic       pick_wr;
  logic       phase_end;

  logic       rd_grant_nxt, wr_grant_nxt, rd_valid_nxt, wr_done_nxt;
  logic [7:0] rd_data_nxt;
  logic       cs_n_nxt, ad_n_nxt, wr_n_nxt, rd_n_nxt, ad_oe_nxt, busy_nxt;
  logic [7:0] ad_out_nxt;

  assign phase_end = (cnt == 8'd0);

`ifdef RTC_ARB_WR_PRIORITY_EN
  // Fixed priority: a pending write always beats a pending read.
  assign pick_wr = wr_req;
`else
  // Round-robin: with both pending, the side not served last time wins.
  // last_wr = 0 means the read side was served last.
  logic last_wr;

  assign pick_wr = wr_req && (!rd_req || !last_wr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr <= 1'b0;
    end else if (state == IDLE && (wr_req || rd_req)) begin
      last_wr <= pick_wr;
    end
  end
`endif

  // Next-state logic: arbitration in IDLE, phase sequencing elsewhere.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr_q;
    data_nxt     = data_q;
    is_wr_nxt    = is_wr;
    rd_grant_nxt = 1'b0;
    wr_grant_nxt = 1'b0;
    rd_valid_nxt = 1'b0;
    wr_done_nxt  = 1'b0;
    rd_data_nxt  = rd_data;

    if (state == IDLE) begin
      if (wr_req || rd_req) begin
        state_nxt = ADDR_SETUP;
        cnt_nxt   = PHASE_LOAD;
        if (pick_wr) begin
          is_wr_nxt    = 1'b1;
          addr_nxt     = wr_addr;
          data_nxt     = wr_data;
          wr_grant_nxt = 1'b1;
        end else begin
          is_wr_nxt    = 1'b0;
          addr_nxt     = rd_addr;
          rd_grant_nxt = 1'b1;
        end
      end
    end else if (!phase_end) begin
      cnt_nxt = cnt - 8'd1;
    end else begin
      cnt_nxt = PHASE_LOAD;
      case (state)
        ADDR_SETUP:  state_nxt = ADDR_STROBE;
        ADDR_STROBE: state_nxt = ADDR_HOLD;
        ADDR_HOLD:   state_nxt = DATA_SETUP;
        DATA_SETUP:  state_nxt = DATA_STROBE;
        DATA_STROBE: begin
          // Last strobe cycle: the chip's data is sampled at this edge.
          state_nxt = DATA_HOLD;
          if (!is_wr) begin
            rd_data_nxt  = ad_in;
            rd_valid_nxt = 1'b1;
          end
        end
        DATA_HOLD: begin
          state_nxt   = RECOVER;
          cnt_nxt     = RECOV_LOAD;
          wr_done_nxt = is_wr;
        end
        RECOVER:     state_nxt = IDLE;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  // Bus level decode from the upcoming state, registered below.
  // The address phase pulses wr_n for both directions (address latch strobe).
  always_comb begin
    cs_n_nxt   = 1'b1;
    ad_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    rd_n_nxt   = 1'b1;
    ad_oe_nxt  = 1'b0;
    ad_out_nxt = 8'h00;
    busy_nxt   = (state_nxt != IDLE);

    case (state_nxt)
      ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
        cs_n_nxt   = 1'b0;
        ad_n_nxt   = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
        wr_n_nxt   = (state_nxt != ADDR_STROBE);
      end
      DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
        cs_n_nxt = 1'b0;
        if (is_wr_nxt) begin
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = data_nxt;
          wr_n_nxt   = (state_nxt != DATA_STROBE);
        end else begin
          rd_n_nxt = (state_nxt != DATA_STROBE);
        end
      end
      default: begin
        cs_n_nxt = 1'b1;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight without pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Captured transaction fields and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      is_wr    <= 1'b0;
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      rd_data  <= 8'h00;
      busy     <= 1'b0;
      cs_n     <= 1'b1;
      ad_n     <= 1'b1;
      wr_n     <= 1'b1;
      rd_n     <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= 8'h00;
    end else begin
      addr_q   <= addr_nxt;
      data_q   <= data_nxt;
      is_wr    <= is_wr_nxt;
      rd_grant <= rd_grant_nxt;
      wr_grant <= wr_grant_nxt;
      rd_valid <= rd_valid_nxt;
      wr_done  <= wr_done_nxt;
      rd_data  <= rd_data_nxt;
      busy     <= busy_nxt;
      cs_n     <= cs_n_nxt;
      ad_n     <= ad_n_nxt;
      wr_n     <= wr_n_nxt;
      rd_n     <= rd_n_nxt;
      ad_oe    <= ad_oe_nxt;
      ad_out   <= ad_out_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_arbiter
//
// Self-checking bench for rtc_bus_arbiter with PHASE_CYC=2 and RECOV_CYC=4,
// which gives a 16-cycle transaction. The stimulus pushes expected pulses
// (grant, wr_done, rd_valid) into a scoreboard queue. A negedge monitor pops
// and compares each pulse the DUT presents, and after every grant it checks
// the bus levels cycle by cycle against the expected shape of a transaction.
// A small RTC bus model latches addresses, stores written data, and returns
// data during read strobes.
// Honours RTC_ARB_WR_PRIORITY_EN for the expected grant order.
// ---------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

  localparam int P_CYC = 2;
  localparam int R_CYC = 4;
  localparam int TXN   = 6 * P_CYC + R_CYC;

  localparam int K_WG = 0;
  localparam int K_RG = 1;
  localparam int K_WD = 2;
  localparam int K_RV = 3;

  // Output vector {cs_n,ad_n,wr_n,rd_n,ad_oe,busy,ad_out,rd_grant,wr_grant,rd_valid,wr_done}.
  localparam logic [17:0] IDLE_EXP = {4'hF, 2'b00, 8'h00, 4'h0};

  logic       clk, reset;
  logic       rd_req, wr_req;
  logic [7:0] rd_addr, wr_addr, wr_data, rd_data, ad_out, ad_in;
  logic       rd_grant, rd_valid, wr_grant, wr_done, busy;
  logic       cs_n, ad_n, wr_n, rd_n, ad_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mem [256];
  logic [7:0] model_addr;

  int         cyc        = 0;
  int         last_grant = 0;
  int         trk_off    = 0;
  bit         trk_on     = 1'b0;
  bit         trk_wr     = 1'b0;
  logic [7:0] trk_a      = 8'h00;
  logic [7:0] trk_d      = 8'h00;

  logic [7:0] sweep_addr [11];
  logic [7:0] sweep_val  [11];

  rtc_bus_arbiter #(.PHASE_CYC(P_CYC), .RECOV_CYC(R_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_grant (rd_grant),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_grant (wr_grant),
    .wr_done  (wr_done),
    .busy     (busy),
    .cs_n     (cs_n),
    .ad_n     (ad_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .ad_in    (ad_in)
  );

  // 10-time-unit clock; posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RTC chip model: the address is latched while the address phase drives the
  // bus, and data is stored during the write strobe of the data phase.
  assign ad_in = (!cs_n && !rd_n) ? mem[model_addr] : 8'h00;

  always @(posedge clk) begin
    if (!cs_n && !ad_n && ad_oe) model_addr = ad_out;
    if (!cs_n && ad_n && !wr_n) mem[model_addr] = ad_out;
  end

  function automatic logic [17:0] out_vec();
    return {cs_n, ad_n, wr_n, rd_n, ad_oe, busy, ad_out, rd_grant, wr_grant, rd_valid, wr_done};
  endfunction

  // Expected {cs_n,ad_n,wr_n,rd_n,ad_oe,busy,drive} at a cycle offset from the grant.
  function automatic logic [13:0] exp_bus(input int off, input bit is_wr,
                                          input logic [7:0] a, input logic [7:0] d);
    logic cs, adn, wrn, rdn, oe, bsy;
    logic [7:0] drv;
    int ph;
    cs = 1'b1; adn = 1'b1; wrn = 1'b1; rdn = 1'b1; oe = 1'b0; bsy = 1'b0; drv = 8'h00;
    ph = off / P_CYC;
    if (off < 6 * P_CYC) begin
      bsy = 1'b1;
      cs  = 1'b0;
      if (ph < 3) begin
        adn = 1'b0;
        oe  = 1'b1;
        drv = a;
        if (ph == 1) wrn = 1'b0;
      end else if (is_wr) begin
        oe  = 1'b1;
        drv = d;
        if (ph == 4) wrn = 1'b0;
      end else if (ph == 4) begin
        rdn = 1'b0;
      end
    end else if (off < TXN) begin
      bsy = 1'b1;
    end
    return {cs, adn, wrn, rdn, oe, bsy, drv};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Pops the scoreboard for one observed pulse and checks it.
  task automatic on_pulse(input int kind);
    exp_t e;
    int   want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_pulse: got pulse kind %0d at cycle %0d, required none", kind, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind) begin
      errors++;
      $display("[TB] FAIL pulse_kind: got kind %0d at cycle %0d, required kind %0d", kind, cyc, e.kind);
      return;
    end
    if (kind == K_WG || kind == K_RG) begin
      if (e.gap != 0) begin
        checks++;
        if (cyc - last_grant != e.gap) begin
          errors++;
          $display("[TB] FAIL grant_gap: got %0d cycles, required %0d", cyc - last_grant, e.gap);
        end
      end
      last_grant = cyc;
      trk_on     = 1'b1;
      trk_off    = 0;
      trk_wr     = (kind == K_WG);
      trk_a      = e.addr;
      trk_d      = e.data;
    end else begin
      want = (kind == K_WD) ? 6 * P_CYC : 5 * P_CYC;
      checks++;
      if (cyc - last_grant != want) begin
        errors++;
        $display("[TB] FAIL pulse_offset: kind %0d got %0d cycles after grant, required %0d",
                 kind, cyc - last_grant, want);
      end
      if (kind == K_RV) begin
        checks++;
        if (rd_data !== e.data) begin
          errors++;
          $display("[TB] FAIL rd_data: got %h, required %h", rd_data, e.data);
        end
      end
    end
  endtask

  // Monitor: checks strobe invariants each cycle, matches pulses against the
  // scoreboard, and follows the bus levels through each granted transaction.
  always @(negedge clk) begin
    logic [13:0] act, want;
    if (reset) begin
      trk_on = 1'b0;
    end else begin
      cyc++;
      checks++;
      if ((!rd_n && !wr_n) || (ad_oe && !rd_n)) begin
        errors++;
        $display("[TB] FAIL strobe_overlap: got rd_n=%b wr_n=%b ad_oe=%b, required no overlap",
                 rd_n, wr_n, ad_oe);
      end
      if (wr_grant) on_pulse(K_WG);
      if (rd_grant) on_pulse(K_RG);
      if (wr_done)  on_pulse(K_WD);
      if (rd_valid) on_pulse(K_RV);
      if (trk_on) begin
        act  = {cs_n, ad_n, wr_n, rd_n, ad_oe, busy, (ad_oe ? ad_out : 8'h00)};
        want = exp_bus(trk_off, trk_wr, trk_a, trk_d);
        checks++;
        if (act !== want) begin
          errors++;
          $display("[TB] FAIL bus_levels: offset %0d got %h, required %h", trk_off, act, want);
        end
        trk_off++;
        if (trk_off > TXN) trk_on = 1'b0;
      end
    end
  end

  // Raises one request, waits (bounded) for its grant, then withdraws it and
  // scrambles the address/data so late sampling would be visible.
  task automatic applyStimulus(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    if (is_wr) begin
      wr_addr = a; wr_data = d; wr_req = 1'b1;
    end else begin
      rd_addr = a; rd_req = 1'b1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (is_wr ? wr_grant : rd_grant) got = 1'b1;
    end
    if (is_wr) wr_req = 1'b0;
    else       rd_req = 1'b0;
    wr_addr = 8'hEE; wr_data = 8'hEE; rd_addr = 8'hEE;
    checkOutput(is_wr ? "wr_grant_wait" : "rd_grant_wait", 32'(got), 32'd1);
  endtask

  task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d, input int gap);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.gap = gap;
    sb.push_back(e);
  endtask

  // Watchdog so a stuck DUT never hangs the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    model_addr = 8'h00;
    sweep_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
    sweep_val  = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE, 8'hC3, 8'h3C, 8'hA5};
    for (int i = 0; i < 11; i++) mem[sweep_addr[i]] = sweep_val[i];

    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = 8'h00; wr_addr = 8'h00; wr_data = 8'h00;

    // Reset state and quiet idle bus.
    #2;
    checkOutput("reset_state", 32'(out_vec()), 32'(IDLE_EXP));
    checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_levels", 32'(out_vec()), 32'(IDLE_EXP));
    end

    // Single write 0x59 to 0x21.
    $display("[TB] write 0x59 to 0x21");
    push(K_WG, 8'h21, 8'h59, 0);
    push(K_WD, 8'h21, 8'h59, 0);
    applyStimulus(1'b1, 8'h21, 8'h59);
    repeat (TXN + 3) @(negedge clk);
    checkOutput("model_mem_0x21", 32'(mem[8'h21]), 32'h59);
    sweep_val[0] = 8'h59;

    // Single read of 0x43 returning 0xA5.
    $display("[TB] read 0x43");
    push(K_RG, 8'h43, 8'h00, 0);
    push(K_RV, 8'h43, 8'hA5, 0);
    applyStimulus(1'b0, 8'h43, 8'h00);
    repeat (TXN + 3) @(negedge clk);

    // Both requests held: grant order and spacing.
    $display("[TB] both requests held");
`ifdef RTC_ARB_WR_PRIORITY_EN
    for (int i = 0; i < 4; i++) begin
      push(K_WG, 8'h50, 8'h66, (i == 0) ? 0 : TXN + 1);
      push(K_WD, 8'h50, 8'h66, 0);
    end
`else
    for (int i = 0; i < 2; i++) begin
      push(K_WG, 8'h50, 8'h66, (i == 0) ? 0 : TXN + 1);
      push(K_WD, 8'h50, 8'h66, 0);
      push(K_RG, 8'h41, 8'h00, TXN + 1);
      push(K_RV, 8'h41, 8'hC3, 0);
    end
`endif
    rd_addr = 8'h41; wr_addr = 8'h50; wr_data = 8'h66;
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0;
    for (int i = 0; i < 120 && n < 4; i++) begin
      @(negedge clk);
      if (wr_grant || rd_grant) n++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    checkOutput("held_grant_count", 32'(n), 32'd4);
    repeat (TXN + 3) @(negedge clk);

    // Reset in the middle of a write data strobe.
    $display("[TB] reset during write strobe");
    push(K_WG, 8'h60, 8'h77, 0);
    applyStimulus(1'b1, 8'h60, 8'h77);
    repeat (4 * P_CYC) @(posedge clk);
    #2;
    checkOutput("pre_reset_wr_n", 32'(wr_n), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_levels", 32'(out_vec()), 32'(IDLE_EXP));
    checkOutput("async_reset_rd_data", 32'(rd_data), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (TXN) @(negedge clk);
    checkOutput("post_reset_idle", 32'(out_vec()), 32'(IDLE_EXP));
    push(K_RG, 8'h22, 8'h00, 0);
    push(K_RV, 8'h22, 8'h32, 0);
    applyStimulus(1'b0, 8'h22, 8'h00);
    repeat (TXN + 3) @(negedge clk);

    // Read sweep across the scanner's register set, back to back.
    $display("[TB] read sweep");
    for (int i = 0; i < 11; i++) begin
      push(K_RG, sweep_addr[i], 8'h00, (i == 0) ? 0 : TXN + 1);
      push(K_RV, sweep_addr[i], sweep_val[i], 0);
      applyStimulus(1'b0, sweep_addr[i], 8'h00);
    end
    repeat (TXN + 4) @(negedge clk);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    checkOutput("final_idle", 32'(out_vec()), 32'(IDLE_EXP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Sole owner of the multiplexed address/data bus to the RTC chip; generates the chip-select, read/write strobe and A/D-select timing.
- Shares the bus between two requesters: the periodic read scanner (register addresses 0x21–0x28, 0x41–0x43) and the user write/configuration path.
- Runs one complete bus transaction per grant (address phase, data phase, recovery), then returns to arbitration.

Parameters:
- PHASE_CYC, 8: clk cycles per bus phase (setup/strobe/hold); legal range 1–255.
- RECOV_CYC, 16: clk cycles with chip-select high between transactions; legal range 1–255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  read request, level; held until rd_grant
- rd_addr  in  8  read register address, captured at grant
- rd_grant  out  1  one-cycle pulse: read accepted
- rd_data  out  8  read result, valid while rd_valid is high; holds until next read
- rd_valid  out  1  one-cycle pulse: rd_data updated
- wr_req  in  1  write request, level; held until wr_grant
- wr_addr  in  8  write register address, captured at grant
- wr_data  in  8  write data, captured at grant
- wr_grant  out  1  one-cycle pulse: write accepted
- wr_done  out  1  one-cycle pulse: write strobe completed
- busy  out  1  high in every state except IDLE
- cs_n  out  1  chip select, active low
- ad_n  out  1  A/D select: 0 = address phase, 1 = data phase
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe, active low
- ad_out  out  8  bus drive value
- ad_oe  out  1  tristate enable for ad_out; the top level owns the pad
- ad_in  in  8  bus sampled value

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE
  - cs_n = ad_n = wr_n = rd_n = 1
  - ad_oe = 0, ad_out = 0x00, rd_data = 0x00
  - all pulses and busy = 0
  - last_served = READ
  - A transaction in flight is abandoned; no done/valid pulse is issued.
- FSM states: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, RECOVER.
  - Each phase state lasts exactly PHASE_CYC cycles, counted by an 8-bit down-counter.
  - RECOVER lasts RECOV_CYC cycles, then the FSM goes to IDLE.
  - IDLE lasts at least 1 cycle.
- Arbitration: evaluated in IDLE only.
  - Single pending request: it wins.
  - Both pending: the one not equal to last_served wins (round-robin).
  - At the IDLE→ADDR_SETUP edge: capture addr (plus data and direction), assert the winner's grant for 1 cycle, update last_served.
  - Requests are ignored outside IDLE.
  - A request still high after grant+1 is treated as a new request.
- Bus levels by state (unlisted signals = 1, or 0 for ad_oe):
  - ADDR_SETUP: cs_n = 0, ad_n = 0, ad_oe = 1, ad_out = addr
  - ADDR_STROBE: as ADDR_SETUP, plus wr_n = 0
  - ADDR_HOLD: as ADDR_SETUP
  - DATA_SETUP, write: cs_n = 0, ad_oe = 1, ad_out = data
  - DATA_SETUP, read: cs_n = 0, ad_oe = 0
  - DATA_STROBE: as DATA_SETUP, plus wr_n = 0 (write) or rd_n = 0 (read)
  - DATA_HOLD: as DATA_SETUP
  - RECOVER: all idle levels, ad_oe = 0
- Read capture:
  - rd_data is registered from ad_in on the last cycle of DATA_STROBE.
  - rd_valid pulses in the first cycle of DATA_HOLD.
- wr_done pulses in the first cycle of RECOVER (write transactions only).
- rd_n and wr_n are never low simultaneously; ad_oe is never 1 while rd_n = 0.
- Transaction length: 6·PHASE_CYC + RECOV_CYC cycles, from grant cycle through last RECOVER cycle. Minimum grant-to-grant spacing is this length + 1.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RTC_ARB_WR_PRIORITY_EN
- Defined: fixed priority; wr_req always wins over rd_req in IDLE, and last_served is ignored.
- Undefined: round-robin as described in Behaviour.

Test Plan (PHASE_CYC=2, RECOV_CYC=4, transaction = 16 cycles):
- Reset released, no requests -> all strobes high, ad_oe = 0, busy = 0 indefinitely.
- wr_req with wr_addr = 0x21, wr_data = 0x59 -> wr_grant pulse, then:
  - 2 cycles ad_n = 0 / ad_out = 0x21 before wr_n falls;
  - wr_n low 2 cycles in each phase;
  - data phase drives 0x59;
  - wr_done at cycle 12 after grant;
  - busy low at cycle 16.
- rd_req with rd_addr = 0x43, ad_in = 0xA5 during DATA_STROBE -> ad_oe = 0 and rd_n = 0 in the data phase; rd_data = 0xA5 with rd_valid pulse; wr_n stays high in the data phase.
- rd_req and wr_req both held continuously -> grants alternate W, R, W, R (first write, since last_served resets to READ), spaced 17 cycles. With RTC_ARB_WR_PRIORITY_EN defined -> W, W, W.
- reset asserted mid-DATA_STROBE of a write -> outputs return to idle levels immediately (asynchronously), no wr_done; after release a new request is granted normally.
- 11-address read sweep 0x21–0x28, 0x41–0x43 -> 11 rd_valid pulses with data matching the bus model, rd_n and wr_n never low together.
